// File: rtl/ac3_pkg.sv
// AC3 shared definitions: drain FSM state encoding and accumulator width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a. Also used by the AC3 controller.
package ac3_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAPT  = 3'd1,
    QUANT = 3'd2,
    SEND  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  // Accumulator width: tree growth + activation bits + weight bits + operand count growth.
  function automatic int acc_w(input int m, input int pa, input int pw, input int mno);
    return $clog2(m) + pa + pw + $clog2(mno);
  endfunction

  // Width of a shift amount able to address every accumulator bit.
  function automatic int sh_w(input int aw);
    return $clog2(aw);
  endfunction

endpackage

// File: rtl/ac3_drain_if.sv
// Activation output stream of the AC3 drain: one signed word per beat plus its register index.
// Latency: n/a (wiring only).
// Backpressure: valid/ready; the master holds every field stable while valid is high and ready is low.
// Ports: out_act/out_idx/out_last/out_valid driven by master, out_ready driven by slave.
interface ac3_drain_if #(
  parameter int PA = 8
);
  logic signed [PA-1:0] out_act;
  logic [1:0]           out_idx;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_act, output out_idx, output out_last, output out_valid,
                  input  out_ready);
  modport slave  (input  out_act, input  out_idx, input  out_last, input  out_valid,
                  output out_ready);
endinterface

// File: rtl/ac3_quant.sv
// Quantizes one accumulator value: round-half-up, arithmetic right shift, saturate, optional ReLU.
// Latency: combinational.
// Backpressure: none.
// Ports: x (AW signed), shift_amt (clamped to AW-1 internally), relu_en, y (PA signed).
module ac3_quant #(
  parameter int AW = 25,
  parameter int SW = 5,
  parameter int PA = 8
) (
  input  logic signed [AW-1:0] x,
  input  logic [SW-1:0]        shift_amt,
  input  logic                 relu_en,
  output logic signed [PA-1:0] y
);
  localparam logic signed [AW:0] MAX_V = (AW+1)'((1 << (PA-1)) - 1);
  localparam logic signed [AW:0] MIN_V = -MAX_V - (AW+1)'(1);

  logic [SW-1:0]      s;
  logic signed [AW:0] bias;
  logic signed [AW:0] r;
  logic signed [AW:0] q;

  always_comb begin
    // Shifts beyond the accumulator's top bit would discard the sign, so clamp them.
    s    = (32'(shift_amt) > AW-1) ? SW'(AW-1) : shift_amt;
    bias = (s != '0) ? ((AW+1)'(1) << (s - SW'(1))) : '0;
    // One extra bit of headroom so adding the rounding bias never wraps.
    r    = {x[AW-1], x} + bias;
    q    = r >>> s;
    y    = q[PA-1:0];
    if (relu_en && q[AW]) begin
      y = '0;
    end else if (q > MAX_V) begin
      y = MAX_V[PA-1:0];
    end else if (q < MIN_V) begin
      y = MIN_V[PA-1:0];
    end
  end

endmodule

// File: rtl/ac3_drain.sv
// Snapshots the four AC3 accumulators, quantizes them and streams four activations, then pulses ac3_clr.
// Latency: start edge k -> CAPT, QUANT, then out_valid from the third edge; clear one cycle after last beat.
// Backpressure: valid/ready; words hold stable while stalled, start is ignored while busy.
// Ports: clk, rst (sync, active high), start/shift_amt/relu_en/in_ac3_0..3 in, out_if stream, ac3_clr, busy.
module ac3_drain
  import ac3_pkg::*;
#(
  parameter int  M   = 16,
  parameter int  Pa  = 8,
  parameter int  Pw  = 4,
  parameter int  MNO = 288,
  localparam int AW  = acc_w(M, Pa, Pw, MNO),
  localparam int SW  = sh_w(AW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SW-1:0]        shift_amt,
  input  logic                 relu_en,
  input  logic signed [AW-1:0] in_ac3_0,
  input  logic signed [AW-1:0] in_ac3_1,
  input  logic signed [AW-1:0] in_ac3_2,
  input  logic signed [AW-1:0] in_ac3_3,
  ac3_drain_if.master          out_if,
  output logic                 ac3_clr,
  output logic                 busy
);
  state_t               state;
  state_t               state_nxt;
  logic signed [AW-1:0] snap [4];
  logic [SW-1:0]        shift_r;
  logic                 relu_r;
  logic signed [Pa-1:0] qv [4];
  logic signed [Pa-1:0] q [4];
  logic [1:0]           idx;
  logic signed [Pa-1:0] act;
  logic                 last;
  logic                 xfer;

  assign xfer = (state == SEND) && out_if.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CAPT;
      CAPT:    state_nxt = QUANT;
      QUANT:   state_nxt = SEND;
      SEND:    if (xfer && idx == 2'd3) state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so nothing reaches them from inputs.
  always_comb begin
    busy             = (state != IDLE);
    ac3_clr          = (state == CLEAR);
    out_if.out_valid = (state == SEND);
  end

  assign out_if.out_act  = act;
  assign out_if.out_idx  = idx;
  assign out_if.out_last = last;

  for (genvar i = 0; i < 4; i++) begin : g_quant
    ac3_quant #(.AW(AW), .SW(SW), .PA(Pa)) u_quant (
      .x         (snap[i]),
      .shift_amt (shift_r),
      .relu_en   (relu_r),
      .y         (qv[i])
    );
  end

  // Snapshot, quantized results and the output word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        snap[i] <= '0;
        q[i]    <= '0;
      end
      shift_r <= '0;
      relu_r  <= 1'b0;
      idx     <= '0;
      act     <= '0;
      last    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            snap[0] <= in_ac3_0;
            snap[1] <= in_ac3_1;
            snap[2] <= in_ac3_2;
            snap[3] <= in_ac3_3;
            shift_r <= shift_amt;
            relu_r  <= relu_en;
          end
        end
        CAPT: begin
          for (int i = 0; i < 4; i++) q[i] <= qv[i];
        end
        QUANT: begin
          idx  <= 2'd0;
          act  <= q[0];
          last <= 1'b0;
        end
        SEND: begin
          // Advance only on an accepted word; the final beat leaves the registers as they are.
          if (xfer && idx != 2'd3) begin
            idx  <= idx + 2'd1;
            act  <= q[idx + 2'd1];
            last <= (idx == 2'd2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
